// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
//   sa_state_t   : controller states (IDLE, RUN, DONE)
//   SA_WIDTH_DEF : default operand/result width
package serial_adder_pkg;

    localparam int unsigned SA_WIDTH_DEF = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

endpackage

// File: rtl/fullAdder.sv
// Team 1-bit full adder cell.
//   a, b, cin : operand bits and carry-in
//   s, cout   : sum bit and carry-out
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one operand bit pair per clock through a
// single full adder cell, result shifted in LSB first.
//   clk, reset        : rising-edge clock, async active-high reset
//   start, a, b, sub  : request pulse and operands (captured in IDLE only)
//   busy, done        : busy in RUN/DONE, done pulses one cycle with result
//   result            : WIDTH-bit modular sum/difference
//   flag_n/z/c/v      : condition flags, built only with SERIAL_ADDER_FLAGS_EN
//                       defined; otherwise tied to 0
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    sa_state_t        state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    // Subtraction is A + ~B + 1: B is inverted here, the +1 is the preset carry.
    fullAdder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0] ^ sub_q),
        .cin  (carry_q),
        .s    (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        sub_d    = sub_q;
        carry_d  = carry_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    sub_d   = sub;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d = {fa_sum, result_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            sub_q    <= sub_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

`ifdef SERIAL_ADDER_FLAGS_EN
    logic msb_cin_q, msb_cin_d;
    logic flag_n_q, flag_n_d;
    logic flag_z_q, flag_z_d;
    logic flag_c_q, flag_c_d;
    logic flag_v_q, flag_v_d;

    // Flags are computed from the MSB step, when carry_q is the MSB carry-in.
    always_comb begin
        msb_cin_d = msb_cin_q;
        flag_n_d  = flag_n_q;
        flag_z_d  = flag_z_q;
        flag_c_d  = flag_c_q;
        flag_v_d  = flag_v_q;
        if (state_q == RUN && last_bit) begin
            msb_cin_d = carry_q;
            flag_n_d  = fa_sum;
            flag_z_d  = (result_d == '0);
            flag_c_d  = fa_cout;
            flag_v_d  = carry_q ^ fa_cout;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msb_cin_q <= 1'b0;
            flag_n_q  <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
            flag_v_q  <= 1'b0;
        end else begin
            msb_cin_q <= msb_cin_d;
            flag_n_q  <= flag_n_d;
            flag_z_q  <= flag_z_d;
            flag_c_q  <= flag_c_d;
            flag_v_q  <= flag_v_d;
        end
    end

    assign flag_n = flag_n_q;
    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
    assign flag_v = flag_v_q;
`else
    assign flag_n = 1'b0;
    assign flag_z = 1'b0;
    assign flag_c = 1'b0;
    assign flag_v = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=64): directed cases from the
// test plan plus randomized operations against an arithmetic reference model.
module tb_serial_adder;

    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         flag_n;
    logic         flag_z;
    logic         flag_c;
    logic         flag_v;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .sub    (sub),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flag_n (flag_n),
        .flag_z (flag_z),
        .flag_c (flag_c),
        .flag_v (flag_v)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: two's-complement arithmetic on a 65-bit sum.
    logic [W-1:0] m_res;
    logic         m_n, m_z, m_c, m_v;

    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W:0]   full;
        logic [W-1:0] yy;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + (W+1)'(s);
        m_res = full[W-1:0];
`ifdef SERIAL_ADDER_FLAGS_EN
        m_c = full[W];
        m_n = m_res[W-1];
        m_z = (m_res == '0);
        m_v = (x[W-1] == yy[W-1]) && (m_res[W-1] != x[W-1]);
`else
        m_c = 1'b0;
        m_n = 1'b0;
        m_z = 1'b0;
        m_v = 1'b0;
`endif
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},   W'(busy),   '0);
        check({tag, "_done"},   W'(done),   '0);
        check({tag, "_result"}, result,     '0);
        check({tag, "_flags"},  W'({flag_n, flag_z, flag_c, flag_v}), '0);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_n"}, W'(flag_n), W'(m_n));
        check({tag, "_z"}, W'(flag_z), W'(m_z));
        check({tag, "_c"}, W'(flag_c), W'(m_c));
        check({tag, "_v"}, W'(flag_v), W'(m_v));
    endtask

    // Full operation: start driven at a negedge, accepted at the next posedge.
    // done must appear exactly W edges later for one cycle.
    task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s, input int unsigned ignore_at);
        int late_done;
        model(x, y, s);
        @(negedge clk);
        a = x; b = y; sub = s; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_run"}, W'(busy), W'(1));
        late_done = 0;
        for (int i = 1; i < int'(W); i++) begin
            if (ignore_at != 0 && i == int'(ignore_at)) begin
                a = 64'd9; b = 64'd9; sub = 1'b0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b1) late_done++;
        end
        start = 1'b0;
        check({tag, "_no_early_done"}, W'(late_done), '0);
        @(negedge clk);
        check({tag, "_done"}, W'(done), W'(1));
        check({tag, "_busy_done"}, W'(busy), W'(1));
        check({tag, "_result"}, result, m_res);
        check_flags(tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, W'(done), '0);
        check({tag, "_idle"}, W'(busy), '0);
        check({tag, "_hold"}, result, m_res);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
        #10;
        check_outputs_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        do_op("add_5_3", 64'd5, 64'd3, 1'b0, 0);
        check("add_5_3_val", result, 64'd8);

        do_op("sub_zero", 64'h1234, 64'h1234, 1'b1, 0);
        check("sub_zero_val", result, 64'd0);

        do_op("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
        check("ovf_val", result, 64'h8000_0000_0000_0000);

        do_op("borrow", 64'd0, 64'd1, 1'b1, 0);
        check("borrow_val", result, {W{1'b1}});

        // start pulse mid-run must be ignored
        do_op("ignore", 64'd5, 64'd3, 1'b0, 10);
        check("ignore_val", result, 64'd8);
        // immediately after the mandatory idle cycle
        do_op("b2b", 64'd100, 64'd27, 1'b1, 0);
        check("b2b_val", result, 64'd73);

        // asynchronous reset partway through an operation
        @(negedge clk);
        a = 64'd5; b = 64'd3; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #10 reset = 1'b1;
        #1;
        check_outputs_zero("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        do_op("after_rst", 64'd5, 64'd3, 1'b0, 0);

        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] ra, rb;
            logic         rs;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rs = 1'($urandom_range(0, 1));
            if (i == 3) rb = ra;
            if (i == 5) ra = 64'h8000_0000_0000_0000;
            do_op($sformatf("rand%0d", i), ra, rb, rs, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
